mips_multicycle_controller: RTL

//  Main control FSM that sequences the shared MIPS datapath (one ALU, one unified memory) over several cycles per instruction.

---
 rtl/mips_ctrl_pkg.sv | 53 +++++
 rtl/mips_alu_decoder.sv | 44 ++++
 rtl/mips_multicycle_controller.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control unit:
// FSM state encoding, instruction field codes, ALU operation classes and
// the ALU control codes driven onto the datapath.
package mips_ctrl_pkg;

  // Controller states. 4-bit encoding leaves three unused values, which
  // the FSM treats as a fault and leaves for FETCH on the next edge.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11,
    ILLEGAL  = 4'd12
  } state_t;

  // Opcodes (instr[31:26]) recognised by the controller
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // What the FSM asks the ALU decoder for
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  // ALU control codes seen by the datapath ALU
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder: turns the FSM's ALU request plus the R-type
// funct field into the ALU control code, and reports whether the funct
// field names an operation this core supports.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int FUNCT_W    = 6,
  parameter int ALU_CTRL_W = 3
) (
  input  alu_op_t                 alu_op,
  input  logic [FUNCT_W-1:0]      funct,
  output logic [ALU_CTRL_W-1:0]   alu_control,
  output logic                    func_valid
);

  // Map request/funct to ALU control; unknown funct falls back to add and
  // is flagged so the FSM can divert the instruction to ILLEGAL.
  always_comb begin
    alu_control = ALU_ADD;
    func_valid  = 1'b1;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD: alu_control = ALU_ADD;
          FN_SUB: alu_control = ALU_SUB;
          FN_AND: alu_control = ALU_AND;
          FN_OR:  alu_control = ALU_OR;
          FN_SLT: alu_control = ALU_SLT;
          default: begin
            alu_control = ALU_ADD;
            func_valid  = 1'b0;
          end
        endcase
      end
      default: begin
        alu_control = ALU_ADD;
        func_valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Main control FSM for the shared-datapath multicycle MIPS. Sequences
// fetch, decode and the per-class execution states, drives every mux
// select and write strobe, waits on the memory-ready handshake, counts
// retired instructions and keeps a sticky illegal-instruction flag.
// All strobes are forced low while rst is high so an aborted instruction
// can never leave a partial write behind.
module mips_multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W       = 6,
  parameter int FUNCT_W    = 6,
  parameter int ALU_CTRL_W = 3,
  parameter int RETIRE_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OP_W-1:0]       opcode,
  input  logic [FUNCT_W-1:0]    funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  iord,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [1:0]            pc_src,
  output logic                  pc_en,
  output logic                  illegal_op,
  output logic [RETIRE_W-1:0]   retired
);

  state_t                r_state;
  state_t                w_next;
  logic [RETIRE_W-1:0]   r_retired;
  logic                  r_illegal;

  // Raw (pre-reset-gating) control decode
  logic                  w_iord;
  logic                  w_mem_write;
  logic                  w_ir_write;
  logic                  w_reg_dst;
  logic                  w_mem_to_reg;
  logic                  w_reg_write;
  logic                  w_alu_src_a;
  logic [1:0]            w_alu_src_b;
  logic [1:0]            w_pc_src;
  logic                  w_pc_write;
  logic                  w_branch;
  logic                  w_alu_used;
  alu_op_t               w_alu_op;
  logic                  w_retire;
  logic                  w_set_illegal;

  logic [ALU_CTRL_W-1:0] w_alu_ctrl;
  logic                  w_func_valid;

  mips_alu_decoder #(
    .FUNCT_W    (FUNCT_W),
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_alu_decoder (
    .alu_op      (w_alu_op),
    .funct       (funct),
    .alu_control (w_alu_ctrl),
    .func_valid  (w_func_valid)
  );

  // State register; reset aborts whatever instruction was in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    w_next        = FETCH;
    w_iord        = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_reg_dst     = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_reg_write   = 1'b0;
    w_alu_src_a   = 1'b0;
    w_alu_src_b   = 2'b00;
    w_pc_src      = 2'b00;
    w_pc_write    = 1'b0;
    w_branch      = 1'b0;
    w_alu_used    = 1'b0;
    w_alu_op      = ALUOP_ADD;
    w_retire      = 1'b0;
    w_set_illegal = 1'b0;

    case (r_state)
      FETCH: begin
        // PC+4 is computed every cycle, but IR and PC only load once
        // memory actually delivers the instruction.
        w_alu_src_b = 2'b01;
        w_alu_used  = 1'b1;
        if (mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = DECODE;
        end else begin
          w_next = FETCH;
        end
      end

      DECODE: begin
        // Precompute the branch target while the opcode is examined
        w_alu_src_b = 2'b11;
        w_alu_used  = 1'b1;
        if (opcode == OP_LW || opcode == OP_SW) begin
          w_next = MEMADR;
        end else if (opcode == OP_RTYPE) begin
          w_next = EXECUTE;
        end else if (opcode == OP_BEQ) begin
          w_next = BRANCH;
        end else if (opcode == OP_ADDI) begin
          w_next = ADDIEXEC;
        end else if (opcode == OP_J) begin
          w_next = JUMP;
        end else begin
          w_next = ILLEGAL;
        end
      end

      MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu_used  = 1'b1;
        // Only lw/sw reach here, and IR is stable after FETCH
        w_next      = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
      end

      MEMREAD: begin
        w_iord = 1'b1;
        w_next = mem_ready ? MEMWB : MEMREAD;
      end

      MEMWB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_next       = FETCH;
      end

      MEMWRITE: begin
        // Strobe stays up until memory accepts the store
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
        if (mem_ready) begin
          w_retire = 1'b1;
          w_next   = FETCH;
        end else begin
          w_next = MEMWRITE;
        end
      end

      EXECUTE: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b00;
        w_alu_used  = 1'b1;
        w_alu_op    = ALUOP_FUNCT;
        w_next      = w_func_valid ? ALUWB : ILLEGAL;
      end

      ALUWB: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_next      = FETCH;
      end

      BRANCH: begin
        // Compare A-B; PC loads the precomputed target only when zero
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b00;
        w_alu_used  = 1'b1;
        w_alu_op    = ALUOP_SUB;
        w_pc_src    = 2'b01;
        w_branch    = 1'b1;
        w_retire    = 1'b1;
        w_next      = FETCH;
      end

      ADDIEXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu_used  = 1'b1;
        w_next      = ADDIWB;
      end

      ADDIWB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_next      = FETCH;
      end

      JUMP: begin
        w_pc_src   = 2'b10;
        w_pc_write = 1'b1;
        w_retire   = 1'b1;
        w_next     = FETCH;
      end

      ILLEGAL: begin
        // No writes; the instruction is simply dropped
        w_set_illegal = 1'b1;
        w_next        = FETCH;
      end

      default: begin
        w_next = FETCH;
      end
    endcase
  end

  // Retired-instruction counter, wraps naturally at 2^RETIRE_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + RETIRE_W'(1);
    end
  end

  // Sticky illegal-instruction flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else if (w_set_illegal) begin
      r_illegal <= 1'b1;
    end
  end

  // Reset gates every datapath control combinationally so strobes drop
  // in the same cycle rst rises, not at the next clock edge.
  assign iord        = w_iord       & ~rst;
  assign mem_write   = w_mem_write  & ~rst;
  assign ir_write    = w_ir_write   & ~rst;
  assign reg_dst     = w_reg_dst    & ~rst;
  assign mem_to_reg  = w_mem_to_reg & ~rst;
  assign reg_write   = w_reg_write  & ~rst;
  assign alu_src_a   = w_alu_src_a  & ~rst;
  assign alu_src_b   = rst ? 2'b00 : w_alu_src_b;
  assign pc_src      = rst ? 2'b00 : w_pc_src;
  assign alu_control = (rst || !w_alu_used) ? '0 : w_alu_ctrl;
  assign pc_en       = (w_pc_write | (w_branch & zero)) & ~rst;
  assign illegal_op  = r_illegal;
  assign retired     = r_retired;

endmodule
